// File: rtl/bcd_mod_counter_pkg.sv
// Shared definitions for the two-digit BCD modulo counter.
//   BCD_W     : width of one BCD digit
//   bcd2_t    : packed {tens, ones} pair, the counter state
//   bcd_valid : true when a 4-bit code is a legal BCD digit (0..9)
package bcd_mod_counter_pkg;

   localparam int BCD_W = 4;

   typedef struct packed {
      logic [BCD_W-1:0] tens;
      logic [BCD_W-1:0] ones;
   } bcd2_t;

   function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
      return digit <= BCD_W'(9);
   endfunction

endpackage

// File: rtl/bcd_mod_counter_if.sv
// Control/data bundle between the counter and its user.
//   master : drives en, up_dn, clr, load, load_tens, load_ones;
//            observes bcd_tens, bcd_ones, tick, carry
//   slave  : the counter side (inverse directions)
interface bcd_mod_counter_if;
   import bcd_mod_counter_pkg::*;

   logic             en;
   logic             up_dn;
   logic             clr;
   logic             load;
   logic [BCD_W-1:0] load_tens;
   logic [BCD_W-1:0] load_ones;
   logic [BCD_W-1:0] bcd_tens;
   logic [BCD_W-1:0] bcd_ones;
   logic             tick;
   logic             carry;

   modport master (
      output en, up_dn, clr, load, load_tens, load_ones,
      input  bcd_tens, bcd_ones, tick, carry
   );

   modport slave (
      input  en, up_dn, clr, load, load_tens, load_ones,
      output bcd_tens, bcd_ones, tick, carry
   );

endinterface

// File: rtl/bcd_mod_counter_tick_gen.sv
// Prescaler: free-running 0..TICK_DIV-1 counter producing a registered
// one-clock tick. The tick rises on the cycle after the count reaches
// TICK_DIV-1, so the first tick comes TICK_DIV clocks after reset/restart.
//   clk     : system clock
//   rst_n   : async active-low reset
//   restart : synchronous return to count 0, tick low
//   tick    : one-cycle pulse every TICK_DIV clocks
module tick_gen #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         tick  <= 1'b0;
      end else if (restart) begin
         cnt_q <= '0;
         tick  <= 1'b0;
      end else begin
         tick  <= (cnt_q == LAST);
         cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (00..MODULO-1) with prescaled count tick,
// up/down stepping with wrap, one-cycle carry/borrow pulse, synchronous
// clear and validated parallel load.
//   clk   : system clock, rising edge
//   rst_n : async active-low reset
//   bus   : slave side of bcd_mod_counter_if
//           (en, up_dn, clr, load, load_tens, load_ones in;
//            bcd_tens, bcd_ones, tick, carry out)
// Priority: clr > load > (tick & en) step > hold.
module bcd_mod_counter
   import bcd_mod_counter_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int MODULO   = 60
) (
   input  logic               clk,
   input  logic               rst_n,
   bcd_mod_counter_if.slave   bus
);

   localparam logic [BCD_W-1:0] MOD_TENS = BCD_W'((MODULO - 1) / 10);
   localparam logic [BCD_W-1:0] MOD_ONES = BCD_W'((MODULO - 1) % 10);
   localparam bcd2_t            TOP_VAL  = '{tens: MOD_TENS, ones: MOD_ONES};

   logic  tick_w;
   bcd2_t cnt_q;
   logic  carry_q;

   // clr also restarts the prescaler so the next tick is a full period away
   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (bus.clr),
      .tick    (tick_w)
   );

   // Load validation: bad digits or an out-of-range value load 00
   logic [7:0] ld_val;
   logic       ld_ok;
   bcd2_t      ld_cnt;

   always_comb begin
      ld_val = 8'(bus.load_tens) * 8'd10 + 8'(bus.load_ones);
      ld_ok  = bcd_valid(bus.load_tens) && bcd_valid(bus.load_ones) &&
               (ld_val < 8'(MODULO));
      ld_cnt = ld_ok ? bcd2_t'{tens: bus.load_tens, ones: bus.load_ones} : '0;
   end

   // Next value for a tick step; wrap flags the carry/borrow
   bcd2_t step_val;
   logic  step_wrap;

   always_comb begin
      step_val  = cnt_q;
      step_wrap = 1'b0;
      if (bus.up_dn) begin
         if (cnt_q == TOP_VAL) begin
            step_val  = '0;
            step_wrap = 1'b1;
         end else if (cnt_q.ones == BCD_W'(9)) begin
            step_val.ones = '0;
            step_val.tens = cnt_q.tens + BCD_W'(1);
         end else begin
            step_val.ones = cnt_q.ones + BCD_W'(1);
         end
      end else begin
         if (cnt_q == '0) begin
            step_val  = TOP_VAL;
            step_wrap = 1'b1;
         end else if (cnt_q.ones == '0) begin
            step_val.ones = BCD_W'(9);
            step_val.tens = cnt_q.tens - BCD_W'(1);
         end else begin
            step_val.ones = cnt_q.ones - BCD_W'(1);
         end
      end
   end

   // carry is a one-cycle pulse aligned with the first cycle of the wrapped value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         carry_q <= 1'b0;
         if (bus.clr) begin
            cnt_q <= '0;
         end else if (bus.load) begin
            cnt_q <= ld_cnt;
         end else if (tick_w && bus.en) begin
            cnt_q   <= step_val;
            carry_q <= step_wrap;
         end
      end
   end

   assign bus.bcd_tens = cnt_q.tens;
   assign bus.bcd_ones = cnt_q.ones;
   assign bus.tick     = tick_w;
   assign bus.carry    = carry_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench: TICK_DIV=4 with MODULO=60 (dut) and MODULO=100 (dut2).
// Outputs are sampled 1 time unit after the rising edge.
module tb_bcd_mod_counter;
   import bcd_mod_counter_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   bcd_mod_counter_if bus ();
   bcd_mod_counter_if bus2 ();

   bcd_mod_counter #(.TICK_DIV(4), .MODULO(60)) dut (
      .clk (clk), .rst_n (rst_n), .bus (bus)
   );

   bcd_mod_counter #(.TICK_DIV(4), .MODULO(100)) dut2 (
      .clk (clk), .rst_n (rst_n), .bus (bus2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] lt;
      logic [3:0] lo;
      int         exp;
   } ld_vec_t;

   ld_vec_t vecs [9];

   // {tens, ones, tick, carry}
   function automatic logic [9:0] ex(input int v, input bit t, input bit c);
      return {4'(v / 10), 4'(v % 10), t, c};
   endfunction

   function automatic logic [9:0] act1();
      return {bus.bcd_tens, bus.bcd_ones, bus.tick, bus.carry};
   endfunction

   function automatic logic [9:0] act2();
      return {bus2.bcd_tens, bus2.bcd_ones, bus2.tick, bus2.carry};
   endfunction

   task automatic chk(input string name, input logic [9:0] a, input logic [9:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got %0d%0d tick=%b carry=%b, want %0d%0d tick=%b carry=%b",
                  name, a[9:6], a[5:2], a[1], a[0], e[9:6], e[5:2], e[1], e[0]);
      end
   endtask

   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   // Clear dut; afterwards the prescaler phase is m=0 (tick at m%4==0)
   task automatic do_clr();
      bus.clr = 1'b1;
      clk1();
      bus.clr = 1'b0;
      chk("clr", act1(), ex(0, 0, 0));
   endtask

   task automatic do_load(input logic [3:0] t, input logic [3:0] o);
      bus.load = 1'b1;
      bus.load_tens = t;
      bus.load_ones = o;
      clk1();
      bus.load = 1'b0;
   endtask

   initial begin
      int ev;
      vecs[0] = '{4'd0, 4'd12, 0};
      vecs[1] = '{4'd7, 4'd0,  0};
      vecs[2] = '{4'd4, 4'd5,  45};
      vecs[3] = '{4'd5, 4'd9,  59};
      vecs[4] = '{4'd6, 4'd0,  0};
      vecs[5] = '{4'd9, 4'd9,  0};
      vecs[6] = '{4'd15, 4'd1, 0};
      vecs[7] = '{4'd2, 4'd3,  23};
      vecs[8] = '{4'd1, 4'd10, 0};

      rst_n = 1'b0;
      {bus.en, bus.up_dn, bus.clr, bus.load} = '0;
      {bus.load_tens, bus.load_ones} = '0;
      {bus2.en, bus2.up_dn, bus2.clr, bus2.load} = '0;
      {bus2.load_tens, bus2.load_ones} = '0;

      #12;
      chk("reset", act1(), ex(0, 0, 0));
      clk1();
      rst_n = 1'b1;
      bus.en = 1'b1;
      bus.up_dn = 1'b1;

      // 1: free counting up from reset
      for (int k = 1; k <= 44; k++) begin
         clk1();
         chk("count_up", act1(), ex((k - 1) / 4, (k % 4) == 0, 0));
      end

      // 2: 58 -> 59 -> 00 (carry) -> 01
      bus.en = 1'b0;
      do_clr();
      bus.en = 1'b1;
      bus.up_dn = 1'b1;
      do_load(4'd5, 4'd8);
      chk("load58", act1(), ex(58, 0, 0));
      for (int m = 2; m <= 13; m++) begin
         clk1();
         ev = (m < 5) ? 58 : (m < 9) ? 59 : (m < 13) ? 0 : 1;
         chk("wrap_up", act1(), ex(ev, (m % 4) == 0, m == 9));
      end

      // 3: 01 -> 00 -> 59 (borrow) -> 58
      bus.en = 1'b0;
      do_clr();
      bus.en = 1'b1;
      bus.up_dn = 1'b0;
      do_load(4'd0, 4'd1);
      chk("load01", act1(), ex(1, 0, 0));
      for (int m = 2; m <= 13; m++) begin
         clk1();
         ev = (m < 5) ? 1 : (m < 9) ? 0 : (m < 13) ? 59 : 58;
         chk("wrap_dn", act1(), ex(ev, (m % 4) == 0, m == 9));
      end

      // 4: load validation table
      bus.en = 1'b0;
      foreach (vecs[i]) begin
         do_load(4'd3, 4'd3);
         do_load(vecs[i].lt, vecs[i].lo);
         chk($sformatf("load_vec%0d", i),
             {bus.bcd_tens, bus.bcd_ones, 1'b0, bus.carry}, ex(vecs[i].exp, 0, 0));
      end

      // 5a: clr + load on a tick that would otherwise wrap 59 -> 00
      do_clr();
      do_load(4'd5, 4'd9);
      for (int m = 2; m <= 4; m++) clk1();
      chk("pre_tick59", act1(), ex(59, 1, 0));
      bus.clr = 1'b1;
      bus.load = 1'b1;
      bus.load_tens = 4'd4;
      bus.load_ones = 4'd5;
      bus.en = 1'b1;
      bus.up_dn = 1'b1;
      clk1();
      bus.clr = 1'b0;
      bus.load = 1'b0;
      chk("clr_load_tick", act1(), ex(0, 0, 0));
      for (int m = 1; m <= 8; m++) begin
         clk1();
         chk("after_clr", act1(), ex((m >= 5) ? 1 : 0, (m % 4) == 0, 0));
      end
      // 5b: load on a tick cycle wins, step discarded
      do_load(4'd2, 4'd7);
      chk("load_tick", act1(), ex(27, 0, 0));
      for (int m = 10; m <= 13; m++) begin
         clk1();
         chk("after_load", act1(), ex((m < 13) ? 27 : 28, (m % 4) == 0, 0));
      end

      // 6: hold while disabled, then async reset mid-cycle
      bus.en = 1'b0;
      do_clr();
      do_load(4'd3, 4'd7);
      for (int m = 2; m <= 20; m++) begin
         clk1();
         chk("hold", act1(), ex(37, (m % 4) == 0, 0));
      end
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst", act1(), ex(0, 0, 0));
      clk1();
      chk("in_rst", act1(), ex(0, 0, 0));
      rst_n = 1'b1;
      bus.en = 1'b1;
      bus.up_dn = 1'b1;
      for (int m = 1; m <= 5; m++) begin
         clk1();
         chk("resume", act1(), ex((m == 5) ? 1 : 0, (m % 4) == 0, 0));
      end

      // MODULO=100: 99 is loadable, 98 -> 99 -> 00 (carry) -> 01
      bus2.load = 1'b1;
      bus2.load_tens = 4'd9;
      bus2.load_ones = 4'd9;
      clk1();
      bus2.load = 1'b0;
      chk("m100_load99", {bus2.bcd_tens, bus2.bcd_ones, 1'b0, bus2.carry}, ex(99, 0, 0));
      bus2.clr = 1'b1;
      clk1();
      bus2.clr = 1'b0;
      chk("m100_clr", act2(), ex(0, 0, 0));
      bus2.load = 1'b1;
      bus2.load_tens = 4'd9;
      bus2.load_ones = 4'd8;
      bus2.en = 1'b1;
      bus2.up_dn = 1'b1;
      clk1();
      bus2.load = 1'b0;
      chk("m100_load98", act2(), ex(98, 0, 0));
      for (int m = 2; m <= 13; m++) begin
         clk1();
         ev = (m < 5) ? 98 : (m < 9) ? 99 : (m < 13) ? 0 : 1;
         chk("m100_wrap", act2(), ex(ev, (m % 4) == 0, m == 9));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
